// File: rtl/spi_flash_responder_pkg.sv
// Shared types and opcodes for the SPI flash responder.
package spi_flash_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_STATUS,
    ST_ID,
    ST_IGNORE
  } state_t;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_RDID = 8'h9F;

  // JEDEC ID bytes go out most-significant first, index 0..2.
  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
    case (idx)
      2'd0:    id_byte = id[23:16];
      2'd1:    id_byte = id[15:8];
      default: id_byte = id[7:0];
    endcase
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes the SPI pins into clk and derives SCK/CSB edge strobes.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic sck,
  input  logic csb,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic csb_fall,
  output logic csb_high,
  output logic mosi_bit,
  output logic armed
);

  logic [2:0] pins;
  logic [2:0] synced;
  logic [1:0] prev;
  logic       armed_reg;
  logic       sel_active;

  assign pins = {mosi, csb, sck};

  // Chains clear to 0 so a CSB already low at reset release never looks like a fresh fall.
  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    logic [SYNC_STAGES-1:0] chain_reg;
    always_ff @(posedge clk) begin
      if (srst) chain_reg <= '0;
      else      chain_reg <= {chain_reg[SYNC_STAGES-2:0], pins[gi]};
    end
    assign synced[gi] = chain_reg[SYNC_STAGES-1];
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_edge
    logic prev_reg;
    always_ff @(posedge clk) begin
      if (srst) prev_reg <= 1'b0;
      else      prev_reg <= synced[gi];
    end
    assign prev[gi] = prev_reg;
  end

  // CSB must be seen high once after reset before a selection is honoured.
  always_ff @(posedge clk) begin
    if (srst)           armed_reg <= 1'b0;
    else if (synced[1]) armed_reg <= 1'b1;
  end

  assign sel_active = armed_reg & ~synced[1];
  assign sck_rise   = sel_active &  synced[0] & ~prev[0];
  assign sck_fall   = sel_active & ~synced[0] &  prev[0];
  assign csb_fall   = armed_reg  &  prev[1]   & ~synced[1];
  assign csb_high   = synced[1];
  assign mosi_bit   = synced[2];
  assign armed      = armed_reg;

endmodule

// File: rtl/spi_flash_responder.sv
// Mode-0 SPI flash responder: READ/RDSR/RDID served from an external byte memory.
module spi_flash_responder
  import spi_flash_responder_pkg::*;
#(
  parameter int          ADDR_W      = 16,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
  parameter logic [7:0]  STATUS_VAL  = 8'h00,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_sck_i,
  input  logic              spi_csb_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              busy_o,
  output logic              cmd_err_o
);

  logic sck_rise, sck_fall, csb_fall, csb_high, mosi_bit, armed;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
    .clk      (clk_i),
    .srst     (rst_i),
    .sck      (spi_sck_i),
    .csb      (spi_csb_i),
    .mosi     (spi_mosi_i),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .csb_fall (csb_fall),
    .csb_high (csb_high),
    .mosi_bit (mosi_bit),
    .armed    (armed)
  );

  state_t            state_reg;
  logic [4:0]        bit_cnt_reg;
  logic [22:0]       shift_in_reg;
  logic [23:0]       addr_reg;
  logic [7:0]        tx_reg;
  logic [2:0]        tx_cnt_reg;
  logic [7:0]        stage_reg;
  logic              rd_wait_reg;
  logic [1:0]        id_idx_reg;
  logic              miso_reg;
  logic              oe_reg;
  logic              mem_req_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic              busy_reg;
  logic              cmd_err_reg;

  logic [7:0]  opcode_next;
  logic [23:0] addr_shift_next;
  logic [23:0] addr_inc_next;
  logic [7:0]  tx_byte_next;

  assign opcode_next     = {shift_in_reg[6:0], mosi_bit};
  assign addr_shift_next = {shift_in_reg, mosi_bit};
  assign addr_inc_next   = addr_reg + 24'd1;

  always_comb begin
    tx_byte_next = stage_reg;
    case (state_reg)
      ST_STATUS: tx_byte_next = STATUS_VAL;
      ST_ID:     tx_byte_next = id_byte(JEDEC_ID, id_idx_reg);
      default:   tx_byte_next = stage_reg;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ST_IDLE;
      bit_cnt_reg  <= '0;
      shift_in_reg <= '0;
      addr_reg     <= '0;
      tx_reg       <= '0;
      tx_cnt_reg   <= '0;
      stage_reg    <= '0;
      rd_wait_reg  <= 1'b0;
      id_idx_reg   <= '0;
      miso_reg     <= 1'b0;
      oe_reg       <= 1'b0;
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= '0;
      busy_reg     <= 1'b0;
      cmd_err_reg  <= 1'b0;
    end else begin
      mem_req_reg <= 1'b0;
      cmd_err_reg <= 1'b0;
      busy_reg    <= armed & ~csb_high;
      rd_wait_reg <= mem_req_reg;
      if (rd_wait_reg) stage_reg <= mem_rdata_i;

      // Deselect overrides everything, including an SCK edge in the same cycle.
      if (csb_high) begin
        state_reg <= ST_IDLE;
        oe_reg    <= 1'b0;
        miso_reg  <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (csb_fall) begin
              state_reg   <= ST_CMD;
              bit_cnt_reg <= '0;
              tx_cnt_reg  <= '0;
              id_idx_reg  <= '0;
            end
          end
          ST_CMD: begin
            if (sck_rise) begin
              shift_in_reg <= addr_shift_next[22:0];
              bit_cnt_reg  <= bit_cnt_reg + 5'd1;
              if (bit_cnt_reg == 5'd7) begin
                bit_cnt_reg <= '0;
                case (opcode_next)
                  CMD_READ: state_reg <= ST_ADDR;
                  CMD_RDSR: state_reg <= ST_STATUS;
                  CMD_RDID: state_reg <= ST_ID;
                  default: begin
                    state_reg   <= ST_IGNORE;
                    cmd_err_reg <= 1'b1;
                  end
                endcase
              end
            end
          end
          ST_ADDR: begin
            if (sck_rise) begin
              shift_in_reg <= addr_shift_next[22:0];
              bit_cnt_reg  <= bit_cnt_reg + 5'd1;
              if (bit_cnt_reg == 5'd23) begin
                addr_reg     <= addr_shift_next;
                mem_addr_reg <= addr_shift_next[ADDR_W-1:0];
                mem_req_reg  <= 1'b1;
                state_reg    <= ST_DATA;
              end
            end
          end
          ST_DATA, ST_STATUS, ST_ID: begin
            if (sck_fall) begin
              oe_reg <= 1'b1;
              if (tx_cnt_reg == 3'd0) begin
                miso_reg   <= tx_byte_next[7];
                tx_reg     <= {tx_byte_next[6:0], 1'b0};
                tx_cnt_reg <= 3'd7;
                if (state_reg == ST_ID)
                  id_idx_reg <= (id_idx_reg == 2'd2) ? 2'd0 : id_idx_reg + 2'd1;
              end else begin
                miso_reg   <= tx_reg[7];
                tx_reg     <= {tx_reg[6:0], 1'b0};
                tx_cnt_reg <= tx_cnt_reg - 3'd1;
              end
              // Prefetch the next byte while bit 0 of the current one is on the wire.
              if (state_reg == ST_DATA && tx_cnt_reg == 3'd1) begin
                addr_reg     <= addr_inc_next;
                mem_addr_reg <= addr_inc_next[ADDR_W-1:0];
                mem_req_reg  <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign spi_miso_o    = miso_reg;
  assign spi_miso_oe_o = oe_reg;
  assign mem_req_o     = mem_req_reg;
  assign mem_addr_o    = mem_addr_reg;
  assign busy_o        = busy_reg;
  assign cmd_err_o     = cmd_err_reg;

endmodule
